// File: rtl/regbank_pkg.sv
// Shared constants for the register bank: default geometry and the write-counter width.
package regbank_pkg;
    localparam int DEF_WIDTH = 32;
    localparam int DEF_DEPTH = 32;
    localparam int CNT_W     = 16;

    // Saturating increment; the counter sticks at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction
endpackage

// File: rtl/reg_word.sv
// One storage word: async clear, sync flush, write enable.
module reg_word #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             clear_i,
    input  logic             flush_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] word_q;

    always_ff @(posedge clk_i or posedge clear_i) begin
        if (clear_i)      word_q <= '0;
        else if (flush_i) word_q <= '0;
        else if (en_i)    word_q <= d_i;
    end

    assign q_o = word_q;
endmodule

// File: rtl/register_bank.sv
// Two-read, one-write register bank with optional hardwired zero register and write bypass.
module register_bank
    import regbank_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             flush,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr1,
    input  logic [AW-1:0]    raddr2,
    output logic [WIDTH-1:0] rdata1,
    output logic [WIDTH-1:0] rdata2,
    output logic [CNT_W-1:0] wr_count
);
    logic [DEPTH-1:0][WIDTH-1:0] word_q;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic                        wr_ok;

    // A write commits only when not flushing/clearing and not aimed at the zero register.
    assign wr_ok = we & ~flush & ~clear & ((ZERO_REG == 0) || (waddr != '0));

    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        if (ZERO_REG != 0 && i == 0) begin : g_zero
            assign word_q[i] = '0;
        end else begin : g_cell
            reg_word #(.WIDTH(WIDTH)) u_word (
                .clk_i   (clk),
                .clear_i (clear),
                .flush_i (flush),
                .en_i    (wr_ok && (waddr == AW'(i))),
                .d_i     (wdata),
                .q_o     (word_q[i])
            );
        end
    end

    always_comb begin
        rdata1 = word_q[raddr1];
        if (BYPASS != 0 && wr_ok && raddr1 == waddr) rdata1 = wdata;
        if (clear || (ZERO_REG != 0 && raddr1 == '0)) rdata1 = '0;
    end

    always_comb begin
        rdata2 = word_q[raddr2];
        if (BYPASS != 0 && wr_ok && raddr2 == waddr) rdata2 = wdata;
        if (clear || (ZERO_REG != 0 && raddr2 == '0)) rdata2 = '0;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (flush)      cnt_d = '0;
        else if (wr_ok) cnt_d = sat_inc(cnt_q);
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign wr_count = cnt_q;
endmodule

// File: doc/register_bank.md
REGISTER_BANK -- requirements
Module: register_bank

Interface
REQ-001 Parameter WIDTH, default 32: data bits per register.
REQ-002 Parameter DEPTH, default 32: register count, power of two, 2..256; AW = log2(DEPTH).
REQ-003 Parameter ZERO_REG, default 1: register 0 reads 0 and ignores writes.
REQ-004 Parameter BYPASS, default 1: same-cycle write data forwarded to read ports.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 clear  in  1  reset, asynchronous, active-high; clears every register.
REQ-007 flush  in  1  synchronous clear-all, sampled at rising edge.
REQ-008 we  in  1  write enable.
REQ-009 waddr  in  AW  write address.
REQ-010 wdata  in  WIDTH  write data.
REQ-011 raddr1, raddr2  in  AW each  read addresses.
REQ-012 rdata1, rdata2  out  WIDTH each  read data, combinational from address.
REQ-013 wr_count  out  16  count of committed writes since last clear/flush.

Function
REQ-014 Rising edge with we=1, flush=0, waddr non-zero (or ZERO_REG=0): reg[waddr] <= wdata.
REQ-015 we=0: all registers hold value.
REQ-016 flush=1 at edge: all registers <= 0 and wr_count <= 0; flush wins over simultaneous we.
REQ-017 Read ports independent; both may address the same register or waddr in the same cycle.
REQ-018 rdataN = reg[raddrN] when no forwarding applies; read latency 0 cycles.
REQ-019 BYPASS=1, we=1, flush=0, raddrN==waddr, waddr write-eligible: rdataN = wdata in that cycle.
REQ-020 BYPASS=0: rdataN shows the new value only after the write edge (1-cycle write-to-read).
REQ-021 ZERO_REG=1: rdataN = 0 whenever raddrN = 0, regardless of we/bypass.
REQ-022 ZERO_REG=1 and waddr=0: no state change, no forwarding, wr_count not incremented.
REQ-023 wr_count increments by 1 per committed write (REQ-014), saturating at 16'hFFFF.
REQ-024 Out-of-range addresses impossible (DEPTH power of two); no error output.

Reset
REQ-025 clear=1 forces all registers and wr_count to 0 immediately, independent of clk.
REQ-026 While clear=1: writes ignored, rdata1/rdata2 = 0, no forwarding.
REQ-027 clear asserted mid-write edge: clear wins; register ends at 0.
REQ-028 Deassertion of clear: first write accepted at next rising edge after deassertion.

Structure
REQ-029 Shared package regbank_pkg holds default WIDTH/DEPTH constants and the wr_count width constant.
REQ-030 Storage cell is sub-module reg_word (WIDTH-bit, async clear, sync flush, enable), instantiated DEPTH times via generate; index 0 omitted when ZERO_REG=1.
REQ-031 Write-address decode and read muxes in register_bank; no latches, no clock gating.

Verification
REQ-032 clear pulse, then we=1 waddr=5 wdata=32'hDEADBEEF; next cycle raddr1=5 -> rdata1=32'hDEADBEEF, wr_count=1.
REQ-033 BYPASS=1: we=1 waddr=7 wdata=32'h1234 raddr2=7 same cycle -> rdata2=32'h1234 before edge; BYPASS=0 -> old value (0) until edge.
REQ-034 ZERO_REG=1: we=1 waddr=0 wdata=32'hFFFFFFFF -> raddr1=0 reads 0, wr_count unchanged.
REQ-035 Write regs 1..31 with value=index, then flush=1 with we=1 waddr=3 -> all regs read 0, wr_count=0.
REQ-036 clear asserted between edges after writing reg 9=32'hA5 -> rdata for raddr1=9 drops to 0 without clock edge.
REQ-037 WIDTH=8, DEPTH=4: write reg 3=8'h5A, raddr1=raddr2=3 -> both 8'h5A; 65536 writes -> wr_count holds 16'hFFFF.
